// File: rtl/alu_result_reorder.sv
// rtl/alu_result_reorder.sv - restores issue order of adder/multiplier results via an order FIFO and per-unit queues
// Optional sticky flag accumulators (sticky_clr/sticky_exc/sticky_ovf/sticky_unf): define ALU_RESULT_REORDER_STICKY_EN.

module alu_result_reorder_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read once count says it was written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
endmodule

module alu_result_reorder #(
  parameter int ORD_DEPTH = 8,
  parameter int RQ_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ord_valid,
  input  logic        ord_is_mul,
  output logic        ord_ready,
  input  logic        add_valid,
  input  logic [31:0] add_result,
  output logic        add_ready,
  input  logic        mul_valid,
  input  logic [31:0] mul_result,
  input  logic        mul_exception,
  input  logic        mul_overflow,
  input  logic        mul_underflow,
  output logic        mul_ready,
  output logic        out_valid,
  output logic [31:0] out_result,
  output logic        out_exception,
  output logic        out_overflow,
  output logic        out_underflow,
  input  logic        out_ready
`ifdef ALU_RESULT_REORDER_STICKY_EN
  ,
  input  logic        sticky_clr,
  output logic        sticky_exc,
  output logic        sticky_ovf,
  output logic        sticky_unf
`endif
);
  localparam int OAW = $clog2(ORD_DEPTH);
  localparam int QAW = $clog2(RQ_DEPTH);
  localparam logic [OAW:0] ORD_FULL = (OAW+1)'(ORD_DEPTH);
  localparam logic [QAW:0] RQ_FULL  = (QAW+1)'(RQ_DEPTH);

  logic [OAW:0] ord_count;
  logic [QAW:0] add_count, mul_count;
  logic         ord_head_is_mul;
  logic [34:0]  add_head, mul_head;
  logic         ord_push, add_push, mul_push;
  logic         ord_pop, add_pop, mul_pop;
  logic         head_avail, out_free, load;

  // Result entries are packed as {exception, overflow, underflow, result}.
  logic         out_valid_q, out_valid_d;
  logic [34:0]  out_data_q, out_data_d;

  assign ord_ready = !reset && (ord_count != ORD_FULL);
  assign add_ready = !reset && (add_count != RQ_FULL);
  assign mul_ready = !reset && (mul_count != RQ_FULL);

  assign ord_push = ord_valid && ord_ready;
  assign add_push = add_valid && add_ready;
  assign mul_push = mul_valid && mul_ready;

  alu_result_reorder_fifo #(.WIDTH(1), .DEPTH(ORD_DEPTH)) u_ord_q (
    .clk       (clk),
    .reset     (reset),
    .push      (ord_push),
    .push_data (ord_is_mul),
    .pop       (ord_pop),
    .pop_data  (ord_head_is_mul),
    .count     (ord_count)
  );

  alu_result_reorder_fifo #(.WIDTH(35), .DEPTH(RQ_DEPTH)) u_add_q (
    .clk       (clk),
    .reset     (reset),
    .push      (add_push),
    .push_data ({3'b000, add_result}),
    .pop       (add_pop),
    .pop_data  (add_head),
    .count     (add_count)
  );

  alu_result_reorder_fifo #(.WIDTH(35), .DEPTH(RQ_DEPTH)) u_mul_q (
    .clk       (clk),
    .reset     (reset),
    .push      (mul_push),
    .push_data ({mul_exception, mul_overflow, mul_underflow, mul_result}),
    .pop       (mul_pop),
    .pop_data  (mul_head),
    .count     (mul_count)
  );

  // Only the unit named by the oldest tag may retire; the other unit keeps filling its own queue.
  always_comb begin
    out_free    = !out_valid_q || out_ready;
    head_avail  = ord_head_is_mul ? (mul_count != '0) : (add_count != '0);
    load        = out_free && (ord_count != '0) && head_avail;
    ord_pop     = load;
    add_pop     = load && !ord_head_is_mul;
    mul_pop     = load && ord_head_is_mul;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = ord_head_is_mul ? mul_head : add_head;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_result    = out_data_q[31:0];
  assign out_exception = out_data_q[34];
  assign out_overflow  = out_data_q[33];
  assign out_underflow = out_data_q[32];

`ifdef ALU_RESULT_REORDER_STICKY_EN
  logic [2:0] sticky_q, sticky_d;

  // A flag retiring in the same cycle as a clear survives the clear.
  always_comb begin
    sticky_d = sticky_clr ? 3'b000 : sticky_q;
    if (out_valid_q && out_ready) begin
      sticky_d = sticky_d | out_data_q[34:32];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= 3'b000;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_exc = sticky_q[2];
  assign sticky_ovf = sticky_q[1];
  assign sticky_unf = sticky_q[0];
`endif
endmodule

// File: tb/tb_alu_result_reorder.sv
// tb/tb_alu_result_reorder.sv - directed self-checking bench for alu_result_reorder
// Sticky flag checks are included when ALU_RESULT_REORDER_STICKY_EN is defined.

module tb_alu_result_reorder;
  logic        clk = 1'b0;
  logic        reset;
  logic        ord_valid, ord_is_mul, ord_ready;
  logic        add_valid, add_ready;
  logic [31:0] add_result;
  logic        mul_valid, mul_ready;
  logic [31:0] mul_result;
  logic        mul_exception, mul_overflow, mul_underflow;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_exception, out_overflow, out_underflow;
  logic        out_ready;
`ifdef ALU_RESULT_REORDER_STICKY_EN
  logic        sticky_clr, sticky_exc, sticky_ovf, sticky_unf;
`endif

  int checks = 0;
  int errors = 0;
  int contract_viol = 0;
  int add_tags, mul_tags, add_rets, mul_rets;
  logic [34:0] got[$];

  alu_result_reorder #(.ORD_DEPTH(8), .RQ_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .ord_valid     (ord_valid),
    .ord_is_mul    (ord_is_mul),
    .ord_ready     (ord_ready),
    .add_valid     (add_valid),
    .add_result    (add_result),
    .add_ready     (add_ready),
    .mul_valid     (mul_valid),
    .mul_result    (mul_result),
    .mul_exception (mul_exception),
    .mul_overflow  (mul_overflow),
    .mul_underflow (mul_underflow),
    .mul_ready     (mul_ready),
    .out_valid     (out_valid),
    .out_result    (out_result),
    .out_exception (out_exception),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_ready     (out_ready)
`ifdef ALU_RESULT_REORDER_STICKY_EN
    ,
    .sticky_clr    (sticky_clr),
    .sticky_exc    (sticky_exc),
    .sticky_ovf    (sticky_ovf),
    .sticky_unf    (sticky_unf)
`endif
  );

  always #5 clk = ~clk;

  // Records retired beats and tracks the tag/result contract on the unit side.
  always @(posedge clk) begin
    if (reset) begin
      add_tags = 0; mul_tags = 0; add_rets = 0; mul_rets = 0;
    end else begin
      if (ord_valid && ord_ready) begin
        if (ord_is_mul) mul_tags++;
        else add_tags++;
      end
      if (add_valid && add_ready) begin
        add_rets++;
        if (add_rets > add_tags) contract_viol++;
      end
      if (mul_valid && mul_ready) begin
        mul_rets++;
        if (mul_rets > mul_tags) contract_viol++;
      end
      if (out_valid && out_ready) got.push_back({out_exception, out_overflow, out_underflow, out_result});
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) step();
    checks += 6;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
    if ({out_exception, out_overflow, out_underflow} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b exp=000", {out_exception, out_overflow, out_underflow});
    end
    if (ord_ready !== 1'b0) begin errors++; $display("FAIL reset_ord_ready got=%b exp=0", ord_ready); end
    if (add_ready !== 1'b0) begin errors++; $display("FAIL reset_add_ready got=%b exp=0", add_ready); end
    if (mul_ready !== 1'b0) begin errors++; $display("FAIL reset_mul_ready got=%b exp=0", mul_ready); end
    reset = 1'b0;
    #1;
    checks++;
    if ({ord_ready, add_ready, mul_ready} !== 3'b111) begin
      errors++; $display("FAIL release_readies got=%b exp=111", {ord_ready, add_ready, mul_ready});
    end
    step();
  endtask

  task automatic test_in_order;
    int base = got.size();
    out_ready = 1'b1;
    ord_valid = 1'b1; ord_is_mul = 1'b1; step();
    ord_is_mul = 1'b0; step();
    ord_valid = 1'b0;
    add_valid = 1'b1; add_result = 32'h4000_0000; step();
    add_valid = 1'b0; step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL in_order_add_blocked out_valid=%b exp=0", out_valid); end
    mul_valid = 1'b1; mul_result = 32'h4080_0000; step();
    mul_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL in_order_no_bypass out_valid=%b exp=0", out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h4080_0000) begin
      errors++; $display("FAIL in_order_first valid=%b result=%h exp 1/40800000", out_valid, out_result);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h4000_0000) begin
      errors++; $display("FAIL in_order_second valid=%b result=%h exp 1/40000000", out_valid, out_result);
    end
    step();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL in_order_idle out_valid=%b exp=0", out_valid); end
    if (got.size() - base != 2) begin errors++; $display("FAIL in_order_count got=%0d exp=2", got.size() - base); end
  endtask

  task automatic test_order_full;
    int base = got.size();
    out_ready = 1'b1;
    ord_valid = 1'b1; ord_is_mul = 1'b0;
    repeat (8) step();
    checks++;
    if (ord_ready !== 1'b0) begin errors++; $display("FAIL full_ord_ready got=%b exp=0", ord_ready); end
    step();
    ord_valid = 1'b0;
    add_valid = 1'b1; add_result = 32'h100; step();
    add_valid = 1'b0;
    checks++;
    if (ord_ready !== 1'b0) begin errors++; $display("FAIL full_before_retire got=%b exp=0", ord_ready); end
    step();
    checks += 2;
    if (ord_ready !== 1'b1) begin errors++; $display("FAIL full_after_retire got=%b exp=1", ord_ready); end
    if (out_valid !== 1'b1 || out_result !== 32'h100) begin
      errors++; $display("FAIL full_first_beat valid=%b result=%h exp 1/00000100", out_valid, out_result);
    end
    for (int i = 1; i < 8; i++) begin
      add_valid = 1'b1; add_result = 32'h100 + 32'(i); step();
    end
    add_valid = 1'b0;
    repeat (3) step();
    checks += 2;
    if (got.size() - base != 8) begin errors++; $display("FAIL full_beats got=%0d exp=8", got.size() - base); end
    if (got[base+7] !== 35'h107) begin errors++; $display("FAIL full_last_beat got=%h exp=107", got[base+7]); end
    // Exactly 8 tags must fit again, proving the blocked ninth push was never recorded.
    ord_valid = 1'b1;
    repeat (7) step();
    checks++;
    if (ord_ready !== 1'b1) begin errors++; $display("FAIL refill_seven got=%b exp=1", ord_ready); end
    step();
    ord_valid = 1'b0;
    checks++;
    if (ord_ready !== 1'b0) begin errors++; $display("FAIL refill_eight got=%b exp=0", ord_ready); end
    for (int i = 0; i < 8; i++) begin
      add_valid = 1'b1; add_result = 32'h200 + 32'(i); step();
    end
    add_valid = 1'b0;
    repeat (3) step();
    checks++;
    if (got.size() - base != 16) begin errors++; $display("FAIL refill_beats got=%0d exp=16", got.size() - base); end
  endtask

  task automatic test_backpressure;
    int base = got.size();
    out_ready = 1'b0;
    ord_valid = 1'b1; ord_is_mul = 1'b0;
    repeat (5) step();
    ord_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      add_valid = 1'b1; add_result = 32'hA1 + 32'(i); step();
      if (i == 2 || i == 3) begin
        checks++;
        if (add_ready !== 1'b1) begin errors++; $display("FAIL bp_add_ready_%0d got=%b exp=1", i, add_ready); end
      end
    end
    add_valid = 1'b0;
    checks++;
    if (add_ready !== 1'b0) begin errors++; $display("FAIL bp_add_ready_full got=%b exp=0", add_ready); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'hA1) begin
        errors++; $display("FAIL bp_hold_%0d valid=%b result=%h exp 1/000000a1", k, out_valid, out_result);
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'hA2 + 32'(k)) begin
        errors++; $display("FAIL bp_drain_%0d valid=%b result=%h exp 1/%h", k, out_valid, out_result, 32'hA2 + 32'(k));
      end
    end
    step();
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle out_valid=%b exp=0", out_valid); end
    if (got.size() - base != 5) begin errors++; $display("FAIL bp_beats got=%0d exp=5", got.size() - base); end
    if (got[base] !== 35'hA1) begin errors++; $display("FAIL bp_first_beat got=%h exp=a1", got[base]); end
  endtask

  task automatic test_nonhead_full;
    out_ready = 1'b1;
    ord_valid = 1'b1; ord_is_mul = 1'b1; step();
    ord_is_mul = 1'b0;
    repeat (4) step();
    ord_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      add_valid = 1'b1; add_result = 32'hB0 + 32'(i); step();
    end
    add_valid = 1'b0;
    checks += 3;
    if (add_ready !== 1'b0) begin errors++; $display("FAIL nh_add_ready got=%b exp=0", add_ready); end
    if (mul_ready !== 1'b1) begin errors++; $display("FAIL nh_mul_ready got=%b exp=1", mul_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL nh_blocked out_valid=%b exp=0", out_valid); end
    mul_valid = 1'b1; mul_result = 32'hC0DE_0000; step();
    mul_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'hC0DE_0000) begin
      errors++; $display("FAIL nh_mul_first valid=%b result=%h exp 1/c0de0000", out_valid, out_result);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'hB0 + 32'(i)) begin
        errors++; $display("FAIL nh_add_%0d valid=%b result=%h exp 1/%h", i, out_valid, out_result, 32'hB0 + 32'(i));
      end
      if (i == 0) begin
        checks++;
        if (add_ready !== 1'b1) begin errors++; $display("FAIL nh_add_ready_freed got=%b exp=1", add_ready); end
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL nh_idle out_valid=%b exp=0", out_valid); end
  endtask

  task automatic test_flags;
    int base = got.size();
    logic [34:0] exp_beats [4];
    exp_beats[0] = {3'b010, 32'h1111_1111};
    exp_beats[1] = {3'b000, 32'h4444_4444};
    exp_beats[2] = {3'b000, 32'h2222_2222};
    exp_beats[3] = {3'b101, 32'h3333_3333};
    out_ready = 1'b1;
    ord_valid = 1'b1;
    ord_is_mul = 1'b1; step();
    ord_is_mul = 1'b0; step();
    ord_is_mul = 1'b1; step();
    step();
    ord_valid = 1'b0;
    add_valid = 1'b1; add_result = 32'h4444_4444;
    mul_valid = 1'b1; mul_result = 32'h1111_1111; mul_overflow = 1'b1; step();
    add_valid = 1'b0;
    mul_result = 32'h2222_2222; mul_overflow = 1'b0; step();
    mul_result = 32'h3333_3333; mul_exception = 1'b1; mul_underflow = 1'b1; step();
    mul_valid = 1'b0; mul_exception = 1'b0; mul_underflow = 1'b0;
    repeat (6) step();
    checks++;
    if (got.size() - base != 4) begin errors++; $display("FAIL flags_beats got=%0d exp=4", got.size() - base); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[base+i] !== exp_beats[i]) begin
        errors++; $display("FAIL flags_beat_%0d got=%h exp=%h", i, got[base+i], exp_beats[i]);
      end
    end
`ifdef ALU_RESULT_REORDER_STICKY_EN
    checks++;
    if ({sticky_exc, sticky_ovf, sticky_unf} !== 3'b111) begin
      errors++; $display("FAIL sticky_set got=%b exp=111", {sticky_exc, sticky_ovf, sticky_unf});
    end
    sticky_clr = 1'b1; step();
    sticky_clr = 1'b0;
    checks++;
    if ({sticky_exc, sticky_ovf, sticky_unf} !== 3'b000) begin
      errors++; $display("FAIL sticky_clear got=%b exp=000", {sticky_exc, sticky_ovf, sticky_unf});
    end
`endif
  endtask

  task automatic test_reset_mid;
    int base;
    logic saw_valid = 1'b0;
    out_ready = 1'b0;
    ord_valid = 1'b1;
    ord_is_mul = 1'b0; step();
    step();
    ord_is_mul = 1'b1; step();
    ord_valid = 1'b0;
    add_valid = 1'b1; add_result = 32'hD1; step();
    add_result = 32'hD2; step();
    add_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'hD1) begin
      errors++; $display("FAIL rm_holding valid=%b result=%h exp 1/000000d1", out_valid, out_result);
    end
    #2 reset = 1'b1;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_async_valid got=%b exp=0", out_valid); end
    if (out_result !== 32'h0) begin errors++; $display("FAIL rm_async_result got=%h exp=0", out_result); end
    if (ord_ready !== 1'b0) begin errors++; $display("FAIL rm_ord_ready_in_reset got=%b exp=0", ord_ready); end
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (ord_ready !== 1'b1) begin errors++; $display("FAIL rm_ord_ready_release got=%b exp=1", ord_ready); end
    base = got.size();
    out_ready = 1'b1;
    repeat (5) begin
      step();
      if (out_valid !== 1'b0) saw_valid = 1'b1;
    end
    checks += 2;
    if (saw_valid !== 1'b0) begin errors++; $display("FAIL rm_stale_valid got=%b exp=0", saw_valid); end
    if (got.size() != base) begin errors++; $display("FAIL rm_stale_beats got=%0d exp=0", got.size() - base); end
    ord_valid = 1'b1; ord_is_mul = 1'b0; step();
    ord_valid = 1'b0;
    add_valid = 1'b1; add_result = 32'hE1; step();
    add_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'hE1) begin
      errors++; $display("FAIL rm_after_reset valid=%b result=%h exp 1/000000e1", out_valid, out_result);
    end
    step();
  endtask

  task automatic test_contract;
    checks++;
    if (contract_viol != 0) begin errors++; $display("FAIL contract_violations got=%0d exp=0", contract_viol); end
  endtask

  initial begin
    reset = 1'b1;
    ord_valid = 1'b0; ord_is_mul = 1'b0;
    add_valid = 1'b0; add_result = '0;
    mul_valid = 1'b0; mul_result = '0;
    mul_exception = 1'b0; mul_overflow = 1'b0; mul_underflow = 1'b0;
    out_ready = 1'b0;
`ifdef ALU_RESULT_REORDER_STICKY_EN
    sticky_clr = 1'b0;
`endif
    test_reset();
    test_in_order();
    test_order_full();
    test_backpressure();
    test_nonhead_full();
    test_flags();
    test_reset_mid();
    test_contract();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
